// File: rtl/jacobi_pkg.sv
// Shared definitions for the Jacobi datapath slice.
//   DATA_W  : V word width
//   ROW_W   : row index width
//   ADDR_W  : V SRAM bank address width
//   N_BANKS : number of V SRAM banks
//   wb_state_t : write-back sequencer states
package jacobi_pkg;
    localparam int unsigned DATA_W  = 48;
    localparam int unsigned ROW_W   = 10;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned N_BANKS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO for buffered write-back results.
// Ports:
//   clock, reset (async active-low)
//   flush        : empties the FIFO (takes priority over push/pop)
//   push/din     : write an entry (ignored when full)
//   pop/dout     : dout shows the head entry; pop advances (ignored when empty)
//   full, empty  : occupancy flags
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 58
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout    = mem[rd_ptr_q[PTR_W-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= din;
    end
endmodule

// File: rtl/v_writeback_sequencer.sv
// v_writeback_sequencer: buffers new V values (tagged with row index) and
// writes them into the four V SRAM banks, in the section not being read.
// Ports:
//   clock, reset (async active-low)
//   start                 : begin iteration, latch write section
//   control_vsram_section : section being read (writes go to the other)
//   in_valid/in_ready/in_row/in_data : result input handshake
//   sram_k_write{Addressline,Enable,Data} (k=1..4) : registered bank writes
//   iter_done             : one-cycle pulse once all N_ROWS rows are written
//   row_err               : sticky, row >= N_ROWS received
//   sig_match             : only with V_WB_SIGNATURE_EN; signature equals
//                           previous iteration's (fixed-point indication)
module v_writeback_sequencer #(
    parameter int unsigned N_ROWS     = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = jacobi_pkg::DATA_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          control_vsram_section,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [jacobi_pkg::ROW_W-1:0]  in_row,
    input  logic [DATA_W-1:0]             in_data,
    output logic [jacobi_pkg::ADDR_W-1:0] sram_1_writeAddressline,
    output logic                          sram_1_writeEnable,
    output logic [DATA_W-1:0]             sram_1_writeData,
    output logic [jacobi_pkg::ADDR_W-1:0] sram_2_writeAddressline,
    output logic                          sram_2_writeEnable,
    output logic [DATA_W-1:0]             sram_2_writeData,
    output logic [jacobi_pkg::ADDR_W-1:0] sram_3_writeAddressline,
    output logic                          sram_3_writeEnable,
    output logic [DATA_W-1:0]             sram_3_writeData,
    output logic [jacobi_pkg::ADDR_W-1:0] sram_4_writeAddressline,
    output logic                          sram_4_writeEnable,
    output logic [DATA_W-1:0]             sram_4_writeData,
`ifdef V_WB_SIGNATURE_EN
    output logic                          sig_match,
`endif
    output logic                          iter_done,
    output logic                          row_err
);
    import jacobi_pkg::*;

    localparam int unsigned CNT_W   = 11;
    localparam logic [CNT_W-1:0] ROWS = CNT_W'(N_ROWS);
    localparam int unsigned ENTRY_W = ROW_W + DATA_W;

    wb_state_t state_q, state_d;
    logic                           wsec_q;
    logic [CNT_W-1:0]               acc_cnt_q;
    logic [CNT_W-1:0]               wr_cnt_q;
    logic                           row_err_q;
    logic                           done_q;
    logic [N_BANKS-1:0]             we_q;
    logic [N_BANKS-1:0][ADDR_W-1:0] addr_q;
    logic [N_BANKS-1:0][DATA_W-1:0] data_q;

    logic               xfer, in_range, push, pop, done_evt;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [ROW_W-1:0]   pop_row;
    logic [DATA_W-1:0]  pop_data;

    assign in_ready = (state_q == ACTIVE) && !fifo_full;
    // start wins over a coincident transfer or pop: the iteration restarts clean.
    assign xfer     = in_valid && in_ready && !start;
    assign in_range = ({1'b0, in_row} < ROWS);
    assign push     = xfer && in_range;
    assign pop      = !fifo_empty && !start;
    assign {pop_row, pop_data} = fifo_dout;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (start),
        .push  (push),
        .din   ({in_row, in_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ACTIVE leaves on the edge accepting the final row, so no extra row is
    // accepted beyond N_ROWS.
    always_comb begin
        state_d  = state_q;
        done_evt = 1'b0;
        if (start) begin
            state_d = ACTIVE;
        end else begin
            case (state_q)
                ACTIVE: if (push && (acc_cnt_q == ROWS - 1'b1)) state_d = DRAIN;
                DRAIN: begin
                    if (fifo_empty && (wr_cnt_q == ROWS)) begin
                        state_d  = DONE;
                        done_evt = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wsec_q    <= 1'b0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            row_err_q <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_evt;
            we_q    <= '0;
            if (start) begin
                wsec_q    <= ~control_vsram_section;
                acc_cnt_q <= '0;
                wr_cnt_q  <= '0;
                row_err_q <= 1'b0;
            end else begin
                if (push) acc_cnt_q <= acc_cnt_q + 1'b1;
                if (xfer && !in_range) row_err_q <= 1'b1;
                if (pop) begin
                    wr_cnt_q              <= wr_cnt_q + 1'b1;
                    we_q[pop_row[1:0]]    <= 1'b1;
                    addr_q[pop_row[1:0]]  <= {wsec_q, pop_row[ROW_W-1:2]};
                    data_q[pop_row[1:0]]  <= pop_data;
                end
            end
        end
    end

`ifdef V_WB_SIGNATURE_EN
    logic [DATA_W-1:0] sig_q;
    logic [DATA_W-1:0] sig_prev_q;
    logic              sig_match_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q       <= '0;
            sig_prev_q  <= '0;
            sig_match_q <= 1'b0;
        end else if (start) begin
            sig_q       <= '0;
            sig_match_q <= 1'b0;
        end else begin
            if (pop) sig_q <= {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ pop_data;
            // The final write landed an edge earlier, so sig_q is complete here.
            if (done_evt) begin
                sig_match_q <= (sig_q == sig_prev_q);
                sig_prev_q  <= sig_q;
            end
        end
    end

    assign sig_match = sig_match_q;
`endif

    assign iter_done = done_q;
    assign row_err   = row_err_q;

    assign sram_1_writeEnable      = we_q[0];
    assign sram_2_writeEnable      = we_q[1];
    assign sram_3_writeEnable      = we_q[2];
    assign sram_4_writeEnable      = we_q[3];
    assign sram_1_writeAddressline = addr_q[0];
    assign sram_2_writeAddressline = addr_q[1];
    assign sram_3_writeAddressline = addr_q[2];
    assign sram_4_writeAddressline = addr_q[3];
    assign sram_1_writeData        = data_q[0];
    assign sram_2_writeData        = data_q[1];
    assign sram_3_writeData        = data_q[2];
    assign sram_4_writeData        = data_q[3];
endmodule

// File: tb/tb_v_writeback_sequencer.sv
module tb_v_writeback_sequencer;
    localparam int N_ROWS     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 48;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic control_vsram_section = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [9:0] in_row = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [8:0] a1, a2, a3, a4;
    logic we1, we2, we3, we4;
    logic [DATA_W-1:0] d1, d2, d3, d4;
    logic iter_done, row_err;
`ifdef V_WB_SIGNATURE_EN
    logic sig_match;
`endif

    v_writeback_sequencer #(
        .N_ROWS     (N_ROWS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .start                   (start),
        .control_vsram_section   (control_vsram_section),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_row                  (in_row),
        .in_data                 (in_data),
        .sram_1_writeAddressline (a1),
        .sram_1_writeEnable      (we1),
        .sram_1_writeData        (d1),
        .sram_2_writeAddressline (a2),
        .sram_2_writeEnable      (we2),
        .sram_2_writeData        (d2),
        .sram_3_writeAddressline (a3),
        .sram_3_writeEnable      (we3),
        .sram_3_writeData        (d3),
        .sram_4_writeAddressline (a4),
        .sram_4_writeEnable      (we4),
        .sram_4_writeData        (d4),
`ifdef V_WB_SIGNATURE_EN
        .sig_match               (sig_match),
`endif
        .iter_done               (iter_done),
        .row_err                 (row_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [1:0]        bank;
        logic [8:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t pend[$];      // results accepted but not yet written
    bit  m_active;     // block is taking new rows
    int  m_acc, m_wr;
    bit  m_err, m_wsec;
    bit  e_we, e_done, done_next;
    wr_t e_wr;
`ifdef V_WB_SIGNATURE_EN
    logic [DATA_W-1:0] m_sig, m_prev;
    bit m_match;
`endif

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend.delete();
            m_active = 0; m_acc = 0; m_wr = 0; m_err = 0; m_wsec = 0;
            e_we = 0; e_done = 0; done_next = 0; e_wr = '0;
`ifdef V_WB_SIGNATURE_EN
            m_sig = '0; m_prev = '0; m_match = 0;
`endif
        end else begin
            bit rdy;
            rdy = m_active && (pend.size() < FIFO_DEPTH);
            e_done = done_next;
            done_next = 0;
            e_we = 0;
            if (start) begin
                pend.delete();
                m_acc = 0; m_wr = 0; m_err = 0; m_active = 1; e_done = 0;
                m_wsec = !control_vsram_section;
`ifdef V_WB_SIGNATURE_EN
                m_sig = '0; m_match = 0;
`endif
            end else begin
                if (pend.size() > 0) begin
                    e_wr = pend.pop_front();
                    e_we = 1;
                    m_wr++;
`ifdef V_WB_SIGNATURE_EN
                    m_sig = {m_sig[DATA_W-2:0], m_sig[DATA_W-1]} ^ e_wr.data;
`endif
                    if (m_wr == N_ROWS) done_next = 1;
                end
                if (in_valid && rdy) begin
                    if (int'(in_row) < N_ROWS) begin
                        wr_t w;
                        w.bank = in_row[1:0];
                        w.addr = {m_wsec, in_row[9:2]};
                        w.data = in_data;
                        pend.push_back(w);
                        m_acc++;
                        if (m_acc == N_ROWS) m_active = 0;
                    end else begin
                        m_err = 1;
                    end
                end
`ifdef V_WB_SIGNATURE_EN
                if (e_done) begin
                    m_match = (m_sig == m_prev);
                    m_prev = m_sig;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    wr_t obs_log[$];
    int  done_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            logic [3:0] we_act, we_exp;
            logic [8:0] a_act;
            logic [DATA_W-1:0] d_act;
            we_act = {we4, we3, we2, we1};
            we_exp = e_we ? (4'b0001 << e_wr.bank) : 4'b0000;
            chk("write_enables", 64'(we_act), 64'(we_exp));
            case (e_wr.bank)
                2'd0: begin a_act = a1; d_act = d1; end
                2'd1: begin a_act = a2; d_act = d2; end
                2'd2: begin a_act = a3; d_act = d3; end
                default: begin a_act = a4; d_act = d4; end
            endcase
            if (e_we) begin
                chk("write_addr", 64'(a_act), 64'(e_wr.addr));
                chk("write_data", 64'(d_act), 64'(e_wr.data));
            end
            for (int k = 0; k < 4; k++) begin
                if (we_act[k]) begin
                    wr_t o;
                    o.bank = 2'(k);
                    case (k)
                        0: begin o.addr = a1; o.data = d1; end
                        1: begin o.addr = a2; o.data = d2; end
                        2: begin o.addr = a3; o.data = d3; end
                        default: begin o.addr = a4; o.data = d4; end
                    endcase
                    obs_log.push_back(o);
                end
            end
            if (iter_done) done_cnt++;
            chk("iter_done", 64'(iter_done), 64'(e_done));
            chk("row_err", 64'(row_err), 64'(m_err));
            chk("in_ready", 64'(in_ready),
                64'(m_active && (pend.size() < FIFO_DEPTH)));
`ifdef V_WB_SIGNATURE_EN
            chk("sig_match", 64'(sig_match), 64'(m_match));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic sec);
        start = 1'b1;
        control_vsram_section = sec;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [9:0] row, input logic [DATA_W-1:0] data);
        int  n;
        logic rdy;
        n = 0;
        in_valid = 1'b1;
        in_row   = row;
        in_data  = data;
        forever begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                chk("handshake_timeout", 64'(n), 64'(0));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] pack(input logic [1:0] b, input logic [8:0] a,
                                         input logic [DATA_W-1:0] d);
        wr_t w;
        w.bank = b; w.addr = a; w.data = d;
        return 64'(w);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [DATA_W-1:0] rd;

        // reset values
        #3;
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_we", 64'({we4, we3, we2, we1}), 64'(0));
        chk("reset_iter_done", 64'(iter_done), 64'(0));
        chk("reset_row_err", 64'(row_err), 64'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        idle(2);

        // sequential fill, section 0
        obs_log.delete(); done_cnt = 0;
        do_start(1'b0);
        for (int r = 0; r < 8; r++) send(10'(r), DATA_W'(r + 'h100));
        idle(4);
        chk("fill_count", 64'(obs_log.size()), 64'(8));
        if (obs_log.size() == 8) begin
            chk("fill_w0", 64'(obs_log[0]), pack(2'd0, 9'h100, 48'h100));
            chk("fill_w1", 64'(obs_log[1]), pack(2'd1, 9'h100, 48'h101));
            chk("fill_w5", 64'(obs_log[5]), pack(2'd1, 9'h101, 48'h105));
            chk("fill_w7", 64'(obs_log[7]), pack(2'd3, 9'h101, 48'h107));
        end
        chk("fill_done_pulses", 64'(done_cnt), 64'(1));

        // section select
        obs_log.delete();
        do_start(1'b1);
        for (int r = 0; r < 8; r++) send(10'(r), DATA_W'(r + 'h200));
        idle(4);
        if (obs_log.size() == 8) begin
            chk("sec_w0", 64'(obs_log[0]), pack(2'd0, 9'h000, 48'h200));
            chk("sec_w7", 64'(obs_log[7]), pack(2'd3, 9'h001, 48'h207));
        end else chk("sec_count", 64'(obs_log.size()), 64'(8));

        // back-to-back pushes: in_ready must never fall, order preserved
        obs_log.delete();
        do_start(1'b0);
        for (int r = 0; r < 8; r++) send(10'(7 - r), DATA_W'(r + 'h300));
        idle(4);
        if (obs_log.size() == 8) begin
            chk("bp_w0", 64'(obs_log[0]), pack(2'd3, 9'h101, 48'h300));
            chk("bp_w5", 64'(obs_log[5]), pack(2'd2, 9'h100, 48'h305));
        end else chk("bp_count", 64'(obs_log.size()), 64'(8));

        // out-of-range row
        obs_log.delete(); done_cnt = 0;
        do_start(1'b0);
        send(10'd9, 48'hDEAD);
        for (int r = 0; r < 8; r++) send(10'(r), DATA_W'(r + 'h400));
        idle(4);
        chk("oor_row_err", 64'(row_err), 64'(1));
        chk("oor_count", 64'(obs_log.size()), 64'(8));
        chk("oor_done_pulses", 64'(done_cnt), 64'(1));

        // restart with the FIFO holding row 2
        obs_log.delete(); done_cnt = 0;
        do_start(1'b0);
        for (int r = 0; r < 3; r++) send(10'(r), DATA_W'(r + 'h500));
        do_start(1'b0);
        chk("restart_row_err_clear", 64'(row_err), 64'(0));
        for (int r = 0; r < 8; r++) send(10'(r), DATA_W'(r + 'h600));
        idle(4);
        chk("restart_count", 64'(obs_log.size()), 64'(10));
        chk("restart_done_pulses", 64'(done_cnt), 64'(1));

`ifdef V_WB_SIGNATURE_EN
        for (int it = 0; it < 3; it++) begin
            do_start(1'b0);
            for (int r = 0; r < 8; r++)
                send(10'(r), DATA_W'((it == 2 && r == 3) ? 'h77 : (r * 'h1111 + 'hA0)));
            idle(4);
            if (it == 1) chk("sig_same", 64'(sig_match), 64'(1));
            if (it == 2) chk("sig_changed", 64'(sig_match), 64'(0));
        end
`endif

        // randomized iterations
        for (int it = 0; it < 15; it++) begin
            do_start(1'($urandom_range(0, 1)));
            guard = 0;
            while (m_active && guard < 300) begin
                guard++;
                if ($urandom_range(0, 29) == 0) begin
                    do_start(1'($urandom_range(0, 1)));
                end else begin
                    rd = {16'($urandom()), 32'($urandom())};
                    send(10'($urandom_range(0, 11)), rd);
                    idle($urandom_range(0, 2));
                end
            end
            idle(4);
        end

        // asynchronous reset while a write strobe is high
        do_start(1'b1);
        send(10'd0, 48'hABC);
        send(10'd1, 48'hABD);
        chk("pre_reset_we1", 64'(we1), 64'(1));
        #1 reset = 1'b0;
        #1;
        chk("async_reset_we", 64'({we4, we3, we2, we1}), 64'(0));
        chk("async_reset_in_ready", 64'(in_ready), 64'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        idle(2);
        obs_log.delete();
        do_start(1'b0);
        for (int r = 0; r < 8; r++) send(10'(r), DATA_W'(r + 'h700));
        idle(4);
        chk("post_reset_count", 64'(obs_log.size()), 64'(8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
